// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, multiplier and result signals for mult_share_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mult_share_arbiter_if #(
    parameter int W = 4
);
    logic           req0_valid;
    logic [W-1:0]   req0_m;
    logic [W-1:0]   req0_q;
    logic           req0_ready;
    logic           req1_valid;
    logic [W-1:0]   req1_m;
    logic [W-1:0]   req1_q;
    logic           req1_ready;
    logic [W-1:0]   mult_m;
    logic [W-1:0]   mult_q;
    logic [2*W-1:0] mult_p;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_p;
    logic           res_id;
    logic           busy;
    logic [7:0]     done_cnt;

    modport slave (
        input  req0_valid, req0_m, req0_q,
        input  req1_valid, req1_m, req1_q,
        input  mult_p, res_ready,
        output req0_ready, req1_ready,
        output mult_m, mult_q,
        output res_valid, res_p, res_id, busy, done_cnt
    );

    modport master (
        output req0_valid, req0_m, req0_q,
        output req1_valid, req1_m, req1_q,
        output mult_p, res_ready,
        input  req0_ready, req1_ready,
        input  mult_m, mult_q,
        input  res_valid, res_p, res_id, busy, done_cnt
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one combinational WxW multiplier between two
// requesters. Granted operands are held on the multiplier for MULT_LAT cycles,
// then the product is captured and offered on a valid/ready result port.
module mult_share_arbiter #(
    parameter int W        = 4,
    parameter int MULT_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave bus
);
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mult_m_q, mult_m_d;
    logic [W-1:0]   mult_q_q, mult_q_d;
    logic [2*W-1:0] res_p_q, res_p_d;
    logic           res_id_q, res_id_d;
    logic           res_valid_q, res_valid_d;
    logic [7:0]     done_cnt_q, done_cnt_d;

    logic           gnt_any;
    logic           gnt_id;

    // Grant selection: a lone requester wins, a tie goes to the priority holder.
    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        gnt_id  = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
    end

    assign bus.req0_ready = (state_q == IDLE) & gnt_any & ~gnt_id;
    assign bus.req1_ready = (state_q == IDLE) & gnt_any &  gnt_id;
    assign bus.mult_m     = mult_m_q;
    assign bus.mult_q     = mult_q_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_p      = res_p_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_cnt   = done_cnt_q;

    // Next-state and datapath updates for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        mult_m_d    = mult_m_q;
        mult_q_d    = mult_q_q;
        res_p_d     = res_p_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        done_cnt_d  = done_cnt_q;
        unique case (state_q)
            IDLE: begin
                // In IDLE the granted ready equals gnt_any, so gnt_any is the handshake.
                if (gnt_any) begin
                    mult_m_d = gnt_id ? bus.req1_m : bus.req0_m;
                    mult_q_d = gnt_id ? bus.req1_q : bus.req0_q;
                    res_id_d = gnt_id;
                    prio_d   = ~gnt_id;
                    cnt_d    = CW'(MULT_LAT - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_p_d     = bus.mult_p;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with immediate asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            mult_m_q    <= '0;
            mult_q_q    <= '0;
            res_p_q     <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            mult_m_q    <= mult_m_d;
            mult_q_q    <= mult_q_d;
            res_p_q     <= res_p_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            done_cnt_q  <= done_cnt_d;
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: one instance with MULT_LAT=1 and one
// with MULT_LAT=3, each driving a behavioural combinational multiplier.
module tb_mult_share_arbiter;
    logic clk;
    logic rst1;
    logic rst3;
    int   total;
    int   bad;

    mult_share_arbiter_if #(.W(4)) a1 ();
    mult_share_arbiter_if #(.W(4)) a3 ();

    mult_share_arbiter #(.W(4), .MULT_LAT(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(a1));
    mult_share_arbiter #(.W(4), .MULT_LAT(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(a3));

    assign a1.mult_p = {4'd0, a1.mult_m} * {4'd0, a1.mult_q};
    assign a3.mult_p = {4'd0, a3.mult_m} * {4'd0, a3.mult_q};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        #1;
        total++; if (a1.busy !== 1'b0) begin bad++; $display("FAIL rst_busy1 got=%0d exp=0", a1.busy); end
        total++; if (a1.res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%0d exp=0", a1.res_valid); end
        total++; if (a1.done_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt1 got=%0d exp=0", a1.done_cnt); end
        total++; if (a1.mult_m !== 4'd0 || a1.mult_q !== 4'd0) begin bad++; $display("FAIL rst_mult1 got=%0d,%0d exp=0,0", a1.mult_m, a1.mult_q); end
        total++; if (a1.res_p !== 8'd0 || a1.res_id !== 1'b0) begin bad++; $display("FAIL rst_res1 got=%0d,%0d exp=0,0", a1.res_p, a1.res_id); end
        total++; if (a3.busy !== 1'b0 || a3.res_valid !== 1'b0) begin bad++; $display("FAIL rst_state3 got=%0d,%0d exp=0,0", a3.busy, a3.res_valid); end
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
    endtask

    // Spec scenario 1: single req0 3x5 with MULT_LAT=1.
    task automatic test_single();
        a1.res_ready = 1'b1;
        a1.req0_valid = 1'b1; a1.req0_m = 4'd3; a1.req0_q = 4'd5;
        #1;
        total++; if (a1.req0_ready !== 1'b1 || a1.req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%0d,%0d exp=1,0", a1.req0_ready, a1.req1_ready); end
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b0 || a1.busy !== 1'b1 || a1.req0_ready !== 1'b0) begin bad++; $display("FAIL single_calc got=v%0d b%0d r%0d exp=v0 b1 r0", a1.res_valid, a1.busy, a1.req0_ready); end
        total++; if (a1.mult_m !== 4'd3 || a1.mult_q !== 4'd5) begin bad++; $display("FAIL single_mult got=%0d,%0d exp=3,5", a1.mult_m, a1.mult_q); end
        a1.req0_valid = 1'b0;
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b1 || a1.res_p !== 8'd15 || a1.res_id !== 1'b0) begin bad++; $display("FAIL single_res got=v%0d p%0d id%0d exp=v1 p15 id0", a1.res_valid, a1.res_p, a1.res_id); end
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b0 || a1.busy !== 1'b0 || a1.done_cnt !== 8'd1) begin bad++; $display("FAIL single_done got=v%0d b%0d c%0d exp=v0 b0 c1", a1.res_valid, a1.busy, a1.done_cnt); end
    endtask

    // Spec scenario 2: simultaneous requests, priority alternates.
    task automatic test_arbitration();
        rst1 = 1'b1; #2; rst1 = 1'b0;
        a1.res_ready = 1'b1;
        a1.req0_valid = 1'b1; a1.req0_m = 4'd15; a1.req0_q = 4'd15;
        a1.req1_valid = 1'b1; a1.req1_m = 4'd0;  a1.req1_q = 4'd9;
        #1;
        total++; if (a1.req0_ready !== 1'b1 || a1.req1_ready !== 1'b0) begin bad++; $display("FAIL arb_first got=%0d,%0d exp=1,0", a1.req0_ready, a1.req1_ready); end
        @(negedge clk);
        a1.req0_valid = 1'b0;
        total++; if (a1.req1_ready !== 1'b0) begin bad++; $display("FAIL arb_calc_ready got=%0d exp=0", a1.req1_ready); end
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b1 || a1.res_p !== 8'd225 || a1.res_id !== 1'b0) begin bad++; $display("FAIL arb_res0 got=v%0d p%0d id%0d exp=v1 p225 id0", a1.res_valid, a1.res_p, a1.res_id); end
        @(negedge clk);
        total++; if (a1.req1_ready !== 1'b1 || a1.done_cnt !== 8'd1) begin bad++; $display("FAIL arb_second got=r%0d c%0d exp=r1 c1", a1.req1_ready, a1.done_cnt); end
        @(negedge clk);
        a1.req1_valid = 1'b0;
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b1 || a1.res_p !== 8'd0 || a1.res_id !== 1'b1) begin bad++; $display("FAIL arb_res1 got=v%0d p%0d id%0d exp=v1 p0 id1", a1.res_valid, a1.res_p, a1.res_id); end
        @(negedge clk);
        a1.req0_valid = 1'b1; a1.req0_m = 4'd1; a1.req0_q = 4'd2;
        a1.req1_valid = 1'b1; a1.req1_m = 4'd3; a1.req1_q = 4'd4;
        #1;
        total++; if (a1.req0_ready !== 1'b1 || a1.req1_ready !== 1'b0) begin bad++; $display("FAIL arb_third got=%0d,%0d exp=1,0", a1.req0_ready, a1.req1_ready); end
        @(negedge clk);
        a1.req0_valid = 1'b0;
        a1.req1_valid = 1'b0;
        @(negedge clk);
        total++; if (a1.res_p !== 8'd2 || a1.res_id !== 1'b0) begin bad++; $display("FAIL arb_res2 got=p%0d id%0d exp=p2 id0", a1.res_p, a1.res_id); end
        @(negedge clk);
        total++; if (a1.done_cnt !== 8'd3 || a1.busy !== 1'b0) begin bad++; $display("FAIL arb_cnt got=c%0d b%0d exp=c3 b0", a1.done_cnt, a1.busy); end
    endtask

    // Spec scenario 3: consumer stalls the result for 5 cycles.
    task automatic test_backpressure();
        a1.res_ready = 1'b0;
        a1.req1_valid = 1'b1; a1.req1_m = 4'd6; a1.req1_q = 4'd7;
        @(negedge clk);
        a1.req1_valid = 1'b0;
        a1.req0_valid = 1'b1; a1.req0_m = 4'd2; a1.req0_q = 4'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++; if (a1.res_valid !== 1'b1 || a1.res_p !== 8'd42 || a1.res_id !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=v%0d p%0d id%0d exp=v1 p42 id1", i, a1.res_valid, a1.res_p, a1.res_id); end
            total++; if (a1.req0_ready !== 1'b0 || a1.req1_ready !== 1'b0 || a1.busy !== 1'b1) begin bad++; $display("FAIL bp_ctrl%0d got=r%0d%0d b%0d exp=r00 b1", i, a1.req0_ready, a1.req1_ready, a1.busy); end
            @(negedge clk);
        end
        a1.res_ready = 1'b1;
        @(negedge clk);
        total++; if (a1.busy !== 1'b0 || a1.res_valid !== 1'b0 || a1.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=b%0d v%0d r%0d exp=b0 v0 r1", a1.busy, a1.res_valid, a1.req0_ready); end
        total++; if (a1.done_cnt !== 8'd4) begin bad++; $display("FAIL bp_cnt got=%0d exp=4", a1.done_cnt); end
        @(negedge clk);
        a1.req0_valid = 1'b0;
        @(negedge clk);
        total++; if (a1.res_valid !== 1'b1 || a1.res_p !== 8'd4 || a1.res_id !== 1'b0) begin bad++; $display("FAIL bp_next got=v%0d p%0d id%0d exp=v1 p4 id0", a1.res_valid, a1.res_p, a1.res_id); end
        @(negedge clk);
    endtask

    // Spec scenario 4: reset asserted while the MULT_LAT=3 instance is computing.
    task automatic test_reset_mid_calc();
        a3.res_ready = 1'b1;
        a3.req0_valid = 1'b1; a3.req0_m = 4'd5; a3.req0_q = 4'd6;
        @(negedge clk);
        a3.req0_valid = 1'b0;
        total++; if (a3.busy !== 1'b1 || a3.mult_m !== 4'd5) begin bad++; $display("FAIL rmc_calc got=b%0d m%0d exp=b1 m5", a3.busy, a3.mult_m); end
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        total++; if (a3.busy !== 1'b0 || a3.res_valid !== 1'b0 || a3.done_cnt !== 8'd0) begin bad++; $display("FAIL rmc_rst got=b%0d v%0d c%0d exp=b0 v0 c0", a3.busy, a3.res_valid, a3.done_cnt); end
        total++; if (a3.mult_m !== 4'd0 || a3.mult_q !== 4'd0 || a3.res_p !== 8'd0) begin bad++; $display("FAIL rmc_data got=m%0d q%0d p%0d exp=0,0,0", a3.mult_m, a3.mult_q, a3.res_p); end
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (a3.res_valid !== 1'b0 || a3.busy !== 1'b0) begin bad++; $display("FAIL rmc_quiet%0d got=v%0d b%0d exp=v0 b0", i, a3.res_valid, a3.busy); end
        end
        a3.req1_valid = 1'b1; a3.req1_m = 4'd4; a3.req1_q = 4'd4;
        #1;
        total++; if (a3.req1_ready !== 1'b1) begin bad++; $display("FAIL rmc_new_ready got=%0d exp=1", a3.req1_ready); end
        @(negedge clk);
        a3.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (a3.res_valid !== 1'b0) begin bad++; $display("FAIL rmc_early got=%0d exp=0", a3.res_valid); end
        @(negedge clk);
        total++; if (a3.res_valid !== 1'b1 || a3.res_p !== 8'd16 || a3.res_id !== 1'b1) begin bad++; $display("FAIL rmc_res got=v%0d p%0d id%0d exp=v1 p16 id1", a3.res_valid, a3.res_p, a3.res_id); end
        @(negedge clk);
        total++; if (a3.done_cnt !== 8'd1 || a3.busy !== 1'b0) begin bad++; $display("FAIL rmc_cnt got=c%0d b%0d exp=c1 b0", a3.done_cnt, a3.busy); end
    endtask

    // Spec scenario 6: operands held 3 cycles, product exactly 3 edges after accept.
    task automatic test_latency3();
        a3.res_ready = 1'b1;
        a3.req1_valid = 1'b1; a3.req1_m = 4'd7; a3.req1_q = 4'd9;
        #1;
        total++; if (a3.req1_ready !== 1'b1 || a3.req0_ready !== 1'b0) begin bad++; $display("FAIL lat_ready got=%0d,%0d exp=0,1", a3.req0_ready, a3.req1_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a3.req1_valid = 1'b0;
            total++; if (a3.mult_m !== 4'd7 || a3.mult_q !== 4'd9 || a3.res_valid !== 1'b0) begin bad++; $display("FAIL lat_hold%0d got=m%0d q%0d v%0d exp=m7 q9 v0", k, a3.mult_m, a3.mult_q, a3.res_valid); end
        end
        @(negedge clk);
        total++; if (a3.res_valid !== 1'b1 || a3.res_p !== 8'd63 || a3.res_id !== 1'b1) begin bad++; $display("FAIL lat_res got=v%0d p%0d id%0d exp=v1 p63 id1", a3.res_valid, a3.res_p, a3.res_id); end
        @(negedge clk);
        total++; if (a3.done_cnt !== 8'd2) begin bad++; $display("FAIL lat_cnt got=%0d exp=2", a3.done_cnt); end
    endtask

    // Spec scenario 5: 256 back-to-back random operations, done_cnt wraps to 0.
    task automatic test_back_to_back();
        logic [3:0] m;
        logic [3:0] q;
        logic       id;
        logic [7:0] exp_p;
        bit         ok;
        rst1 = 1'b1; #2; rst1 = 1'b0;
        a1.res_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            id    = 1'($urandom_range(0, 1));
            m     = 4'($urandom_range(0, 15));
            q     = 4'($urandom_range(0, 15));
            exp_p = {4'd0, m} * {4'd0, q};
            if (id) begin a1.req1_valid = 1'b1; a1.req1_m = m; a1.req1_q = q; end
            else    begin a1.req0_valid = 1'b1; a1.req0_m = m; a1.req0_q = q; end
            ok = 1'b0;
            for (int t = 0; t < 8; t++) begin
                #1;
                if ((id ? a1.req1_ready : a1.req0_ready) === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            total++; if (!ok) begin bad++; $display("FAIL b2b_accept%0d got=timeout exp=ready", n); end
            @(negedge clk);
            a1.req0_valid = 1'b0;
            a1.req1_valid = 1'b0;
            for (int t = 0; t < 8; t++) begin
                if (a1.res_valid === 1'b1) break;
                @(negedge clk);
            end
            total++; if (a1.res_valid !== 1'b1 || a1.res_p !== exp_p) begin bad++; $display("FAIL b2b_p%0d got=v%0d p%0d exp=v1 p%0d", n, a1.res_valid, a1.res_p, exp_p); end
            total++; if (a1.res_id !== id) begin bad++; $display("FAIL b2b_id%0d got=%0d exp=%0d", n, a1.res_id, id); end
            if (n == 255) begin
                total++; if (a1.done_cnt !== 8'd255) begin bad++; $display("FAIL b2b_cnt255 got=%0d exp=255", a1.done_cnt); end
            end
        end
        @(negedge clk);
        total++; if (a1.done_cnt !== 8'd0 || a1.busy !== 1'b0) begin bad++; $display("FAIL b2b_wrap got=c%0d b%0d exp=c0 b0", a1.done_cnt, a1.busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst1  = 1'b1;
        rst3  = 1'b1;
        a1.req0_valid = 1'b0; a1.req0_m = '0; a1.req0_q = '0;
        a1.req1_valid = 1'b0; a1.req1_m = '0; a1.req1_q = '0;
        a1.res_ready  = 1'b0;
        a3.req0_valid = 1'b0; a3.req0_m = '0; a3.req0_q = '0;
        a3.req1_valid = 1'b0; a3.req1_m = '0; a3.req1_q = '0;
        a3.res_ready  = 1'b0;
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_reset_mid_calc();
        test_latency3();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
